alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Multi-cycle front end for the 6502 ALU. It accepts one architectural operation per valid/ready handshake (ADC, SBC, CMP, logic ops, shifts, rotates, INC/DEC). It drives the ALU control, operand and carry inputs, captures the ALU outputs, and returns the result with N/Z/C/V flags and per-flag write enables over a second valid/ready handshake. It sits between the instruction decoder/microsequencer and the status register/accumulator.

Parameters:
ALU_CTRL_W, 3, width of alu_control; codes ADD, SR, AND, OR, XOR come from the shared params header.
OP_W, 4, width of op_code.

Ports:
clk  input  1  system clock, rising edge.
resetn  input  1  asynchronous, active-low reset.
op_valid  input  1  operation request valid.
op_ready  output  1  sequencer can accept an operation.
op_code  input  OP_W  operation select (see Behaviour).
op_a  input  8  operand A (accumulator or memory value).
op_b  input  8  operand B.
flag_c_in  input  1  current C flag.
flag_d_in  input  1  current D flag.
res_valid  output  1  result valid.
res_ready  input  1  consumer accepts the result.
res_y  output  8  result byte.
res_n, res_z, res_c, res_v  output  1 each  flag values.
res_flags_we  output  4  write enables for {N,Z,C,V}.
res_err  output  1  illegal op_code.
alu_control  output  ALU_CTRL_W  to the ALU.
alu_AI, alu_BI  output  8 each  to the ALU.
alu_carry_in  output  1  to the ALU.
alu_Y  input  8  from the ALU.
alu_carry_out, alu_overflow  input  1 each  from the ALU.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: op_ready=1, res_valid=0, res_y=0, all flags=0, res_flags_we=0, res_err=0, alu_control=ADD, alu_AI=0, alu_BI=0, alu_carry_in=0.
- States: IDLE -> DRIVE -> (ADJUST, decimal only) -> RESULT -> IDLE.
- IDLE: op_ready=1. On op_valid&op_ready, register the ALU drive values and go to DRIVE.
- DRIVE: ALU inputs are stable. At the next edge, capture alu_Y/alu_carry_out/alu_overflow and go to RESULT.
- Latency: res_valid is high 2 cycles after the accept edge. Maximum throughput is one op per 3 cycles; there is no overlap.
- RESULT: res_valid=1 and all res_* outputs are held stable. When res_ready=1, go to IDLE and op_ready returns the following cycle. op_ready=0 in every state other than IDLE.
- Op mapping (control, AI, BI, cin -> flags_we):
  0 ADC: ADD, A, B, C -> NZCV
  1 SBC: ADD, A, ~B, C -> NZCV
  2 CMP: ADD, A, ~B, 1 -> NZC
  3 AND: AND, A, B -> NZ
  4 ORA: OR, A, B -> NZ
  5 EOR: XOR, A, B -> NZ
  6 LSR: SR, A, cin=0 -> NZC
  7 ROR: SR, A, cin=C -> NZC
  8 ASL: ADD, A, A, 0 -> NZC
  9 ROL: ADD, A, A, C -> NZC
  10 INC: ADD, A, 0x00, 1 -> NZ
  11 DEC: ADD, A, 0xFF, 0 -> NZ
- Flag derivation: N=Y[7], Z=(Y==0), C=alu_carry_out, V=alu_overflow. Flags without a write enable still present computed values, but the consumer ignores them.
- Illegal op_code (12-15): full handshake still runs; res_err=1, res_y=op_a, res_flags_we=0.
- op_* inputs are sampled only at the accept edge. Changes afterwards have no effect.
- Reset mid-operation: the pending op is dropped and no res_valid is produced. After reset release the block is in IDLE.

Optional Feature:
DECIMAL_MODE_EN.
- Defined, and flag_d_in=1 with ADC or SBC: DRIVE goes to ADJUST for one extra cycle, so latency is 3.
- ADC adjust: add 0x06 if the low nibble exceeds 9 or the binary half-carry is set. Then add 0x60 and force C=1 if the high nibble exceeds 9 or binary C=1.
- SBC adjust: subtract 0x06 on low-nibble borrow and 0x60 on high borrow. C is the binary carry.
- Half-carry is computed locally from the latched operands; the adjust adders are local, not in the ALU.
- N, Z and V come from the binary result (NMOS behaviour).
- Not defined: flag_d_in is ignored, all ops are binary with latency 2, and no ADJUST state is built.

Test Plan:
- ADC A=0x50 B=0x50 C=0 -> res_y=0xA0, N=1, V=1, C=0, Z=0, we=4'b1111; res_valid exactly 2 cycles after accept.
- SBC A=0x00 B=0x01 C=1 -> 0xFF, C=0, N=1. CMP A=0x40 B=0x40 -> Z=1, C=1, we=4'b1110.
- LSR A=0x01 -> 0x00, Z=1, C=1. ROR A=0x01 C=1 -> 0x80, N=1, C=1. ROL A=0x80 C=1 -> 0x01, C=1.
- Backpressure: hold res_ready=0 for 5 cycles -> res_* stable, op_ready=0, and a second op_valid is not accepted until one cycle after the res handshake.
- Reset pulse in DRIVE -> all outputs at reset values and no res_valid. Illegal op 0xF with A=0x3C -> res_err=1, res_y=0x3C, we=0.
- DECIMAL_MODE_EN with D=1: ADC 0x09+0x01 -> 0x10, C=0, latency 3. ADC 0x99+0x01 -> 0x00, C=1. SBC 0x10-0x01 C=1 -> 0x09, C=1.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: operation request, result return and ALU connection signals of alu_sequencer.
interface alu_sequencer_if #(
  parameter int ALU_CTRL_W = 3,
  parameter int OP_W = 4
);
  logic                  op_valid;
  logic                  op_ready;
  logic [OP_W-1:0]       op_code;
  logic [7:0]            op_a;
  logic [7:0]            op_b;
  logic                  flag_c_in;
  logic                  flag_d_in;
  logic                  res_valid;
  logic                  res_ready;
  logic [7:0]            res_y;
  logic                  res_n;
  logic                  res_z;
  logic                  res_c;
  logic                  res_v;
  logic [3:0]            res_flags_we;
  logic                  res_err;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic [7:0]            alu_AI;
  logic [7:0]            alu_BI;
  logic                  alu_carry_in;
  logic [7:0]            alu_Y;
  logic                  alu_carry_out;
  logic                  alu_overflow;
  modport master (
    output op_valid, op_code, op_a, op_b, flag_c_in, flag_d_in, res_ready,
           alu_Y, alu_carry_out, alu_overflow,
    input  op_ready, res_valid, res_y, res_n, res_z, res_c, res_v, res_flags_we, res_err,
           alu_control, alu_AI, alu_BI, alu_carry_in
  );
  modport slave (
    input  op_valid, op_code, op_a, op_b, flag_c_in, flag_d_in, res_ready,
           alu_Y, alu_carry_out, alu_overflow,
    output op_ready, res_valid, res_y, res_n, res_z, res_c, res_v, res_flags_we, res_err,
           alu_control, alu_AI, alu_BI, alu_carry_in
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle front end for the 6502 ALU; one op per request handshake, result + flags over a second handshake.
// Define DECIMAL_MODE_EN to build the BCD ADJUST step for ADC/SBC with the D flag set.
module alu_sequencer #(
  parameter int ALU_CTRL_W = 3,
  parameter int OP_W = 4
) (
  input logic           clk,
  input logic           resetn,
  alu_sequencer_if.slave bus
);
  typedef logic [OP_W-1:0] op_t;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] ALU_SR  = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR = ALU_CTRL_W'(4);
`ifdef DECIMAL_MODE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, ADJUST = 2'd2, RESULT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, RESULT = 2'd3} state_t;
`endif
  state_t                state_q, state_d;
  logic [ALU_CTRL_W-1:0] ctrl_q, ctrl_d, dc_ctrl;
  logic [7:0]            ai_q, ai_d, bi_q, bi_d, dc_bi, y_q, y_d;
  logic                  cin_q, cin_d, dc_cin;
  logic                  n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;
  logic [3:0]            we_q, we_d, dc_we;
  logic                  err_q, err_d, dc_err;
`ifdef DECIMAL_MODE_EN
  logic                  dec_q, dec_d, sbc_q, sbc_d;
  logic [4:0]            hsum;
  logic                  hc, adc_lo, adc_hi;
  logic [7:0]            adc_t;
  // half-carry is rebuilt from the held operands since the ALU does not export it
  assign hsum   = {1'b0, ai_q[3:0]} + {1'b0, bi_q[3:0]} + {4'b0, cin_q};
  assign hc     = hsum[4];
  assign adc_lo = (y_q[3:0] > 4'd9) || hc;
  assign adc_t  = y_q + (adc_lo ? 8'h06 : 8'h00);
  assign adc_hi = (adc_t[7:4] > 4'd9) || c_q;
`endif
  always_comb begin
    dc_ctrl = ALU_ADD;
    dc_bi = bus.op_b;
    dc_cin = 1'b0;
    dc_we = 4'b1100;
    dc_err = 1'b0;
    case (bus.op_code)
      op_t'(0):  begin dc_cin = bus.flag_c_in; dc_we = 4'b1111; end
      op_t'(1):  begin dc_bi = ~bus.op_b; dc_cin = bus.flag_c_in; dc_we = 4'b1111; end
      op_t'(2):  begin dc_bi = ~bus.op_b; dc_cin = 1'b1; dc_we = 4'b1110; end
      op_t'(3):  dc_ctrl = ALU_AND;
      op_t'(4):  dc_ctrl = ALU_OR;
      op_t'(5):  dc_ctrl = ALU_XOR;
      op_t'(6):  begin dc_ctrl = ALU_SR; dc_bi = 8'h00; dc_we = 4'b1110; end
      op_t'(7):  begin dc_ctrl = ALU_SR; dc_bi = 8'h00; dc_cin = bus.flag_c_in; dc_we = 4'b1110; end
      op_t'(8):  begin dc_bi = bus.op_a; dc_we = 4'b1110; end
      op_t'(9):  begin dc_bi = bus.op_a; dc_cin = bus.flag_c_in; dc_we = 4'b1110; end
      op_t'(10): begin dc_bi = 8'h00; dc_cin = 1'b1; end
      op_t'(11): dc_bi = 8'hFF;
      default:   begin dc_bi = 8'h00; dc_we = 4'b0000; dc_err = 1'b1; end
    endcase
  end
  always_comb begin
    state_d = state_q;
    ctrl_d = ctrl_q;
    ai_d = ai_q;
    bi_d = bi_q;
    cin_d = cin_q;
    y_d = y_q;
    n_d = n_q;
    z_d = z_q;
    c_d = c_q;
    v_d = v_q;
    we_d = we_q;
    err_d = err_q;
`ifdef DECIMAL_MODE_EN
    dec_d = dec_q;
    sbc_d = sbc_q;
`endif
    case (state_q)
      IDLE: if (bus.op_valid) begin
        state_d = DRIVE;
        ctrl_d = dc_ctrl;
        ai_d = bus.op_a;
        bi_d = dc_bi;
        cin_d = dc_cin;
        we_d = dc_we;
        err_d = dc_err;
`ifdef DECIMAL_MODE_EN
        sbc_d = bus.op_code == op_t'(1);
        dec_d = bus.flag_d_in && (bus.op_code == op_t'(0) || bus.op_code == op_t'(1));
`endif
      end
      DRIVE: begin
        y_d = err_q ? ai_q : bus.alu_Y;
        n_d = y_d[7];
        z_d = y_d == 8'h00;
        c_d = bus.alu_carry_out;
        v_d = bus.alu_overflow;
`ifdef DECIMAL_MODE_EN
        state_d = dec_q ? ADJUST : RESULT;
`else
        state_d = RESULT;
`endif
      end
`ifdef DECIMAL_MODE_EN
      ADJUST: begin
        // N/Z/V stay from the binary result, as on the NMOS part
        y_d = sbc_q ? y_q - {(c_q ? 4'h0 : 4'h6), (hc ? 4'h0 : 4'h6)}
                    : adc_t + (adc_hi ? 8'h60 : 8'h00);
        c_d = sbc_q ? c_q : adc_hi;
        state_d = RESULT;
      end
`endif
      RESULT: state_d = bus.res_ready ? IDLE : RESULT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ctrl_q <= ALU_ADD;
      ai_q <= 8'h00;
      bi_q <= 8'h00;
      cin_q <= 1'b0;
      y_q <= 8'h00;
      n_q <= 1'b0;
      z_q <= 1'b0;
      c_q <= 1'b0;
      v_q <= 1'b0;
      we_q <= 4'b0000;
      err_q <= 1'b0;
`ifdef DECIMAL_MODE_EN
      dec_q <= 1'b0;
      sbc_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ctrl_q <= ctrl_d;
      ai_q <= ai_d;
      bi_q <= bi_d;
      cin_q <= cin_d;
      y_q <= y_d;
      n_q <= n_d;
      z_q <= z_d;
      c_q <= c_d;
      v_q <= v_d;
      we_q <= we_d;
      err_q <= err_d;
`ifdef DECIMAL_MODE_EN
      dec_q <= dec_d;
      sbc_q <= sbc_d;
`endif
    end
  end
  assign bus.op_ready = state_q == IDLE;
  assign bus.res_valid = state_q == RESULT;
  assign bus.res_y = y_q;
  assign bus.res_n = n_q;
  assign bus.res_z = z_q;
  assign bus.res_c = c_q;
  assign bus.res_v = v_q;
  assign bus.res_flags_we = we_q;
  assign bus.res_err = err_q;
  assign bus.alu_control = ctrl_q;
  assign bus.alu_AI = ai_q;
  assign bus.alu_BI = bi_q;
  assign bus.alu_carry_in = cin_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: table-driven check of alu_sequencer against a behavioural ALU, with a result scoreboard.
module tb_alu_sequencer;
  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic       d;
    logic [7:0] y;
    logic [3:0] f;
    logic [3:0] we;
    logic       err;
    int         lat;
  } vec_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int failures = 0;
  vec_t exp_q[$];
  vec_t tbl[$];
  logic [8:0] sum;
  always #5 clk = ~clk;
  alu_sequencer_if bus();
  alu_sequencer dut (.clk(clk), .resetn(resetn), .bus(bus));
  always_comb begin
    sum = {1'b0, bus.alu_AI} + {1'b0, bus.alu_BI} + {8'h00, bus.alu_carry_in};
    bus.alu_Y = sum[7:0];
    bus.alu_carry_out = sum[8];
    bus.alu_overflow = (bus.alu_AI[7] == bus.alu_BI[7]) && (sum[7] != bus.alu_AI[7]);
    case (bus.alu_control)
      3'd1: begin bus.alu_Y = {bus.alu_carry_in, bus.alu_AI[7:1]}; bus.alu_carry_out = bus.alu_AI[0]; bus.alu_overflow = 1'b0; end
      3'd2: bus.alu_Y = bus.alu_AI & bus.alu_BI;
      3'd3: bus.alu_Y = bus.alu_AI | bus.alu_BI;
      3'd4: bus.alu_Y = bus.alu_AI ^ bus.alu_BI;
      default: ;
    endcase
  end
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  task automatic check_reset_vals(input string tag);
    chk({tag, " ready/valid"}, {bus.op_ready, bus.res_valid}, 2'b10);
    chk({tag, " res_y"}, bus.res_y, 8'h00);
    chk({tag, " flags/we/err"}, {bus.res_n, bus.res_z, bus.res_c, bus.res_v, bus.res_flags_we, bus.res_err}, 9'h000);
    chk({tag, " alu drive"}, {bus.alu_control, bus.alu_AI, bus.alu_BI, bus.alu_carry_in}, 20'h00000);
  endtask
  task automatic present(input vec_t v);
    bus.op_valid = 1'b1;
    bus.op_code = v.op;
    bus.op_a = v.a;
    bus.op_b = v.b;
    bus.flag_c_in = v.c;
    bus.flag_d_in = v.d;
  endtask
  task automatic accept(input vec_t v);
    @(posedge clk);
    #1;
    exp_q.push_back(v);
    bus.op_valid = 1'b0;
    bus.op_code = 4'($urandom);
    bus.op_a = 8'($urandom);
    bus.op_b = 8'($urandom);
    bus.flag_c_in = 1'($urandom);
    bus.flag_d_in = 1'($urandom);
  endtask
  task automatic collect(input int hold, input string tag);
    int cyc;
    vec_t e;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!bus.res_valid && cyc < 8);
    if (exp_q.size() == 0) begin
      chk({tag, " scoreboard underflow"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, " latency"}, cyc + 1, e.lat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, " held valid/ready/y"}, {bus.res_valid, bus.op_ready, bus.res_y}, {1'b1, 1'b0, e.y});
    end
    chk({tag, " res_y"}, bus.res_y, e.y);
    chk({tag, " res_err"}, bus.res_err, e.err);
    chk({tag, " flags_we"}, bus.res_flags_we, e.we);
    chk({tag, " flags NZCV"}, {bus.res_n, bus.res_z, bus.res_c, bus.res_v} & e.we, e.f & e.we);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, " after handshake valid/ready"}, {bus.res_valid, bus.op_ready}, 2'b01);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.op_valid = 1'b0;
    bus.op_code = 4'h0;
    bus.op_a = 8'h00;
    bus.op_b = 8'h00;
    bus.flag_c_in = 1'b0;
    bus.flag_d_in = 1'b0;
    bus.res_ready = 1'b1;
    //            op     a      b      c     d     y      NZCV     we       err   lat
    tbl.push_back('{4'd0, 8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 4'b1001, 4'b1111, 1'b0, 2});
    tbl.push_back('{4'd1, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 4'b1000, 4'b1111, 1'b0, 2});
    tbl.push_back('{4'd2, 8'h40, 8'h40, 1'b0, 1'b0, 8'h00, 4'b0110, 4'b1110, 1'b0, 2});
    tbl.push_back('{4'd6, 8'h01, 8'h77, 1'b1, 1'b0, 8'h00, 4'b0110, 4'b1110, 1'b0, 2});
    tbl.push_back('{4'd7, 8'h01, 8'h00, 1'b1, 1'b0, 8'h80, 4'b1010, 4'b1110, 1'b0, 2});
    tbl.push_back('{4'd9, 8'h80, 8'h00, 1'b1, 1'b0, 8'h01, 4'b0010, 4'b1110, 1'b0, 2});
    tbl.push_back('{4'd3, 8'hF0, 8'h3C, 1'b1, 1'b0, 8'h30, 4'b0000, 4'b1100, 1'b0, 2});
    tbl.push_back('{4'd4, 8'h0F, 8'h30, 1'b0, 1'b0, 8'h3F, 4'b0000, 4'b1100, 1'b0, 2});
    tbl.push_back('{4'd5, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 4'b0100, 4'b1100, 1'b0, 2});
    tbl.push_back('{4'd8, 8'hC0, 8'h12, 1'b1, 1'b0, 8'h80, 4'b1010, 4'b1110, 1'b0, 2});
    tbl.push_back('{4'd10, 8'hFF, 8'h55, 1'b0, 1'b0, 8'h00, 4'b0100, 4'b1100, 1'b0, 2});
    tbl.push_back('{4'd11, 8'h00, 8'h55, 1'b1, 1'b0, 8'hFF, 4'b1000, 4'b1100, 1'b0, 2});
    tbl.push_back('{4'd15, 8'h3C, 8'hA5, 1'b1, 1'b0, 8'h3C, 4'b0000, 4'b0000, 1'b1, 2});
`ifdef DECIMAL_MODE_EN
    tbl.push_back('{4'd0, 8'h09, 8'h01, 1'b0, 1'b1, 8'h10, 4'b0000, 4'b1111, 1'b0, 3});
    tbl.push_back('{4'd0, 8'h99, 8'h01, 1'b0, 1'b1, 8'h00, 4'b1010, 4'b1111, 1'b0, 3});
    tbl.push_back('{4'd1, 8'h10, 8'h01, 1'b1, 1'b1, 8'h09, 4'b0010, 4'b1111, 1'b0, 3});
`else
    tbl.push_back('{4'd0, 8'h09, 8'h01, 1'b0, 1'b1, 8'h0A, 4'b0000, 4'b1111, 1'b0, 2});
`endif
    #12;
    check_reset_vals("reset");
    resetn = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      present(tbl[i]);
      accept(tbl[i]);
      collect(0, $sformatf("vec%0d", i));
    end
    bus.res_ready = 1'b0;
    present(tbl[0]);
    accept(tbl[0]);
    present(tbl[1]);
    collect(5, "backpressure");
    accept(tbl[1]);
    chk("second op accepted late", bus.op_ready, 1'b0);
    collect(0, "after backpressure");
    present(tbl[12]);
    accept(tbl[12]);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_vals("reset in DRIVE");
    void'(exp_q.pop_back());
    #2;
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("after reset no result", {bus.res_valid, bus.op_ready}, 2'b01);
    end
    chk("scoreboard empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
